// File: rtl/ftdi_to_fifo_wr_controller.sv
// Drains host bytes from an FT245-style synchronous FTDI FIFO into the downstream stream FIFO.
// Latency: a byte sampled on the bus appears on fifo_wrreq/fifo_data one ftdi_clk cycle later.
// Backpressure: bursts start and continue only while the FIFO has headroom; a burst is capped at BURST_MAX bytes.
`timescale 1ns/1ps
module ftdi_to_fifo_wr_controller #(
    parameter int FIFO_DEPTH = 2048,
    parameter int HEADROOM   = 8,
    parameter int BURST_MAX  = 512
) (
    input  logic        ftdi_clk,
    input  logic        rst,
    input  logic        ftdi_rxf_n,
    input  logic [7:0]  ftdi_data,
    output logic        ftdi_oe_n,
    output logic        ftdi_rd_n,
    input  logic [10:0] fifo_usedw,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_data,
    output logic [15:0] rx_byte_cnt,
    output logic        overflow
);

    localparam int          BW          = $clog2(BURST_MAX + 1);
    localparam logic [10:0] USEDW_LIMIT = 11'(FIFO_DEPTH - HEADROOM);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OE,
        S_READ,
        S_RELEASE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [BW-1:0]   burst_cnt;
    logic            space_ok;
    logic            accept;

    // Room for at least HEADROOM more words, so in-flight bytes can never overrun the FIFO.
    assign space_ok = (fifo_usedw < USEDW_LIMIT) && !fifo_full;

    // Bus controls decode straight from the registered state so they are glitch-free.
    assign ftdi_oe_n = (state == S_IDLE);
    assign ftdi_rd_n = (state != S_READ);

    // State register.
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and byte acceptance; the exit edge out of READ still takes its byte.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ftdi_rxf_n && space_ok) begin
                    next_state = S_OE;
                end
            end
            S_OE: begin
                next_state = ftdi_rxf_n ? S_RELEASE : S_READ;
            end
            S_READ: begin
                accept = !ftdi_rxf_n;
                if (ftdi_rxf_n || !space_ok || (accept && burst_cnt == BURST_LAST)) begin
                    next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Per-burst byte count, cleared whenever the bus is idle.
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (state == S_IDLE) begin
            burst_cnt <= '0;
        end else if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    // Write path: register the accepted byte, drop it and flag overflow if the FIFO is full.
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            fifo_wrreq  <= 1'b0;
            fifo_data   <= 8'h00;
            rx_byte_cnt <= 16'h0000;
            overflow    <= 1'b0;
        end else begin
            fifo_wrreq <= accept && !fifo_full;
            if (accept) begin
                fifo_data <= ftdi_data;
            end
            if (accept && fifo_full) begin
                overflow <= 1'b1;
            end
            if (fifo_wrreq) begin
                rx_byte_cnt <= rx_byte_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_to_fifo_wr_controller.sv
// Bench for ftdi_to_fifo_wr_controller: FTDI source model, per-cycle reference model, directed and random phases.
// Latency: expectations for each edge are formed at the preceding negedge and compared at the next negedge.
// Backpressure: FIFO fill level and full flag are driven from knobs, either fixed or randomized.
`timescale 1ns/1ps
module tb_ftdi_to_fifo_wr_controller;

    logic        ftdi_clk = 1'b0;
    logic        rst;
    logic        ftdi_rxf_n;
    logic [7:0]  ftdi_data;
    logic        ftdi_oe_n;
    logic        ftdi_rd_n;
    logic [10:0] fifo_usedw;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [7:0]  fifo_data;
    logic [15:0] rx_byte_cnt;
    logic        overflow;

    always #5 ftdi_clk = ~ftdi_clk;

    ftdi_to_fifo_wr_controller dut (
        .ftdi_clk    (ftdi_clk),
        .rst         (rst),
        .ftdi_rxf_n  (ftdi_rxf_n),
        .ftdi_data   (ftdi_data),
        .ftdi_oe_n   (ftdi_oe_n),
        .ftdi_rd_n   (ftdi_rd_n),
        .fifo_usedw  (fifo_usedw),
        .fifo_full   (fifo_full),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .rx_byte_cnt (rx_byte_cnt),
        .overflow    (overflow)
    );

    // Stimulus knobs.
    logic        k_rst        = 1'b1;
    int          k_avail_pct  = 100;
    bit          k_rand       = 1'b0;
    logic [10:0] k_usedw      = 11'd0;
    logic        k_full       = 1'b0;
    logic [7:0]  src[$];

    // Reference model: expected outputs after the next edge.
    logic        e_oe = 1'b1, e_rd = 1'b1, e_rel = 1'b0, e_wrreq = 1'b0, e_ovf = 1'b0;
    logic [7:0]  e_data = 8'h00;
    logic [15:0] e_cnt = 16'h0000;
    int          e_burst = 0;
    bit          pend_pop = 1'b0;
    bit          model_live = 1'b0;

    // Observation of the DUT for directed expectations.
    int          n_chk = 0, n_pass = 0;
    int          bursts[$], gaps[$];
    int          cur_b = 0, cur_gap = 0, wr_pulses = 0;
    logic        prev_oe = 1'b1;
    logic [7:0]  wr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // One cycle: compare DUT to model, advance FTDI source, drive inputs, predict next edge.
    task automatic step();
        bit space_ok, pop, acc, leave;
        @(negedge ftdi_clk);
        if (model_live) begin
            chk("oe_n", ftdi_oe_n, e_oe);
            chk("rd_n", ftdi_rd_n, e_rd);
            chk("wrreq", fifo_wrreq, e_wrreq);
            if (e_wrreq) chk("fifo_data", fifo_data, e_data);
            chk("rx_byte_cnt", rx_byte_cnt, e_cnt);
            chk("overflow", overflow, e_ovf);
        end
        if (fifo_wrreq === 1'b1) begin
            wr_pulses++;
            cur_b++;
            wr_log.push_back(fifo_data);
        end
        if (ftdi_oe_n === 1'b1 && prev_oe === 1'b0) begin
            bursts.push_back(cur_b);
            cur_b = 0;
            cur_gap = 0;
        end
        if (ftdi_oe_n === 1'b1) cur_gap++;
        if (ftdi_oe_n === 1'b0 && prev_oe === 1'b1) gaps.push_back(cur_gap);
        prev_oe = ftdi_oe_n;
        // The FTDI device advances its queue after every edge it saw a read strobe on.
        if (pend_pop && src.size() > 0) void'(src.pop_front());
        if (k_rand) begin
            rst        = ($urandom_range(999) == 0);
            fifo_usedw = ($urandom_range(9) < 3) ? 11'($urandom_range(2047, 2034)) : 11'($urandom_range(2000));
            fifo_full  = ($urandom_range(199) == 0);
        end else begin
            rst        = k_rst;
            fifo_usedw = k_usedw;
            fifo_full  = k_full;
        end
        ftdi_rxf_n = !(src.size() > 0 && $urandom_range(99) < k_avail_pct);
        ftdi_data  = (src.size() > 0) ? src[0] : 8'($urandom);
        space_ok = (fifo_usedw < 11'd2040) && !fifo_full;
        pop      = !e_rd && !ftdi_rxf_n;
        acc      = pop && !rst;
        pend_pop = pop;
        if (rst) begin
            e_oe = 1'b1; e_rd = 1'b1; e_rel = 1'b0; e_wrreq = 1'b0; e_ovf = 1'b0;
            e_data = 8'h00; e_cnt = 16'h0000; e_burst = 0;
            model_live = 1'b1;
        end else begin
            e_cnt   = e_cnt + (e_wrreq ? 16'd1 : 16'd0);
            e_wrreq = acc && !fifo_full;
            if (acc) e_data = ftdi_data;
            if (acc && fifo_full) e_ovf = 1'b1;
            if (!e_rd) begin
                leave = ftdi_rxf_n || !space_ok || (acc && e_burst == 511);
                if (acc) e_burst++;
                if (leave) begin
                    e_rd = 1'b1;
                    e_rel = 1'b1;
                end
            end else if (e_oe) begin
                e_burst = 0;
                if (!ftdi_rxf_n && space_ok) begin
                    e_oe = 1'b0;
                    e_rel = 1'b0;
                end
            end else if (e_rel) begin
                e_oe = 1'b1;
            end else if (!ftdi_rxf_n) begin
                e_rd = 1'b0;
            end else begin
                e_rel = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        src.delete();
        k_rst = 1'b1;
        step();
        step();
        k_rst = 1'b0;
        step();
        bursts.delete();
        gaps.delete();
        wr_log.delete();
        cur_b = 0;
        wr_pulses = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src.size() > 0 || !e_oe || e_wrreq) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", src.size(), 0);
        step();
        step();
    endtask

    initial begin
        int bad;
        rst = 1'b1; ftdi_rxf_n = 1'b1; ftdi_data = 8'h00; fifo_usedw = 11'd0; fifo_full = 1'b0;

        // Reset state.
        do_reset();
        chk("rst_oe_n", ftdi_oe_n, 1);
        chk("rst_rd_n", ftdi_rd_n, 1);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_cnt", rx_byte_cnt, 0);
        chk("rst_ovf", overflow, 0);

        // Single byte.
        src.push_back(8'hA5);
        drain(50);
        chk("single_pulses", wr_pulses, 1);
        chk("single_data", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'hA5);
        chk("single_cnt", rx_byte_cnt, 1);
        chk("single_bursts", bursts.size(), 1);

        // Long stream: 1300 incrementing bytes.
        do_reset();
        for (int i = 0; i < 1300; i++) src.push_back(8'(i));
        drain(2000);
        chk("long_nbursts", bursts.size(), 3);
        if (bursts.size() == 3) begin
            chk("long_b0", bursts[0], 512);
            chk("long_b1", bursts[1], 512);
            chk("long_b2", bursts[2], 276);
        end
        if (gaps.size() == 3) begin
            chk("long_gap1", gaps[1], 1);
            chk("long_gap2", gaps[2], 1);
        end
        chk("long_cnt", rx_byte_cnt, 1300);
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != 8'(i)) bad++;
        chk("long_order_errs", bad, 0);
        chk("long_logged", wr_log.size(), 1300);

        // Throttle on fill level.
        do_reset();
        for (int i = 0; i < 300; i++) src.push_back(8'($urandom));
        repeat (40) step();
        k_usedw = 11'd2040;
        repeat (20) step();
        chk("thr_oe_n_held", ftdi_oe_n, 1);
        chk("thr_rd_n_held", ftdi_rd_n, 1);
        k_usedw = 11'd2039;
        drain(600);
        k_usedw = 11'd0;
        chk("thr_cnt", rx_byte_cnt, 300);
        chk("thr_pulses", wr_pulses, 300);
        chk("thr_ovf", overflow, 0);

        // FTDI empties after 37 bytes, then more data arrives.
        do_reset();
        for (int i = 0; i < 37; i++) src.push_back(8'($urandom));
        drain(200);
        chk("rxf37_pulses", wr_pulses, 37);
        for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
        drain(200);
        chk("rxf37_cnt", rx_byte_cnt, 42);
        chk("rxf37_bursts", bursts.size(), 2);

        // Forced full during READ drops exactly one byte.
        do_reset();
        for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
        for (int n = 0; n < 50 && e_rd; n++) step();
        chk("full_in_read", e_rd, 0);
        k_full = 1'b1;
        step();
        k_full = 1'b0;
        drain(300);
        chk("full_ovf", overflow, 1);
        chk("full_cnt", rx_byte_cnt, 19);
        chk("full_pulses", wr_pulses, 19);
        repeat (5) step();
        chk("full_ovf_sticky", overflow, 1);
        do_reset();
        chk("full_ovf_cleared", overflow, 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 50; i++) src.push_back(8'($urandom));
        for (int n = 0; n < 100 && wr_pulses < 10; n++) step();
        chk("mid_pulses", wr_pulses, 10);
        k_rst = 1'b1;
        step();
        k_rst = 1'b0;
        step();
        chk("mid_oe_n", ftdi_oe_n, 1);
        chk("mid_rd_n", ftdi_rd_n, 1);
        chk("mid_wrreq", fifo_wrreq, 0);
        chk("mid_cnt", rx_byte_cnt, 0);
        src.delete();
        drain(20);

        // Randomized traffic, fill level, full and occasional reset.
        do_reset();
        for (int i = 0; i < 1500; i++) src.push_back(8'($urandom));
        k_rand = 1'b1;
        k_avail_pct = 70;
        repeat (3000) step();
        k_rand = 1'b0;
        k_avail_pct = 100;
        drain(3000);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 65537; i++) src.push_back(8'($urandom));
        drain(70000);
        chk("wrap_pulses", wr_pulses, 65537);
        chk("wrap_cnt", rx_byte_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
